// File: rtl/flash_bootloader.sv
// rtl/flash_bootloader.sv - copies a boot image from x16 parallel NOR flash into RAM after reset.
// Optional trailer checksum verification is enabled with `define BOOT_CHECKSUM_EN.
module flash_bootloader #(
    parameter logic [22:0] FLASH_BASE = 23'h000000,
    parameter int          RAM_AW     = 18,
    parameter logic [RAM_AW-1:0] RAM_BASE = '0,
    parameter int          WORD_COUNT = 512,
    parameter int          READ_WAIT  = 4,
    parameter int          WE_PULSE   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [22:0]       flash_addr,
    inout  wire  [15:0]       flash_data,
    output logic              flash_byte,
    output logic              flash_vpen,
    output logic              flash_rp,
    output logic              flash_ce,
    output logic              flash_oe,
    output logic              flash_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_data,
    output logic              ram_valid,
    input  logic              ram_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       word_idx,
    output logic [15:0]       checksum
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic              boot_err
`endif
);

`ifdef BOOT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam logic [15:0] WC16 = 16'(WORD_COUNT);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_RECOV, S_SETUP, S_WAIT, S_LATCH, S_WRITE, S_DONE
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt;
    logic [15:0] idx;
    logic [15:0] idx_inc;
    logic        cmd_last, read_last, reading, trailer, launch;

    assign idx_inc   = idx + 16'd1;
    assign cmd_last  = (cnt == 16'(WE_PULSE - 1));
    assign read_last = (cnt == 16'(READ_WAIT - 1));
    assign reading   = (state == S_SETUP) || (state == S_WAIT);
    // With checksum enabled, the read at idx == WORD_COUNT fetches the trailer word.
    assign trailer   = CHK_EN && (idx == WC16);
    assign launch    = ((state == S_IDLE) || (state == S_DONE)) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            ram_data <= '0;
        end else begin
            state <= state_n;
            if (launch) begin
                cnt <= '0;
                idx <= '0;
            end else if (state == S_CMD) begin
                cnt <= cmd_last ? 16'd0 : cnt + 16'd1;
            end else if (reading) begin
                cnt <= read_last ? 16'd0 : cnt + 16'd1;
                // oe goes high in LATCH, so the bus is sampled at the close of the read window.
                if (read_last && !trailer)
                    ram_data <= flash_data;
            end else if ((state == S_WRITE) && ram_ready) begin
                idx <= idx_inc;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:          if (start) state_n = S_CMD;
            S_CMD:           if (cmd_last) state_n = S_RECOV;
            S_RECOV:         state_n = S_SETUP;
            S_SETUP, S_WAIT: state_n = read_last ? S_LATCH : S_WAIT;
            S_LATCH:         state_n = trailer ? S_DONE : S_WRITE;
            S_WRITE: begin
                if (ram_ready)
                    state_n = (idx_inc == WC16 && !CHK_EN) ? S_DONE : S_SETUP;
            end
            S_DONE:          if (start) state_n = S_CMD;
            default:         state_n = S_IDLE;
        endcase
    end

    assign flash_byte = 1'b1;
    assign flash_vpen = 1'b1;
    assign flash_rp   = 1'b1;
    assign flash_ce   = !((state == S_CMD) || reading);
    assign flash_oe   = !reading;
    assign flash_we   = !(state == S_CMD);
    assign flash_data = (state == S_CMD) ? 16'h00FF : 16'hzzzz;
    assign flash_addr = FLASH_BASE + {6'b0, idx, 1'b0};
    assign ram_addr   = RAM_BASE + RAM_AW'(idx);
    assign ram_valid  = (state == S_WRITE);
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);
    assign word_idx   = idx;

`ifdef BOOT_CHECKSUM_EN
    logic [15:0] sum;
    logic        err;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
            err <= 1'b0;
        end else if (launch) begin
            sum <= '0;
            err <= 1'b0;
        end else if ((state == S_WRITE) && ram_ready) begin
            sum <= sum + ram_data;
        end else if (reading && read_last && trailer) begin
            err <= (flash_data != sum);
        end
    end

    assign checksum = sum;
    assign boot_err = err;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_flash_bootloader.sv
// tb/tb_flash_bootloader.sv - randomized scoreboard bench for flash_bootloader (optionally with BOOT_CHECKSUM_EN).
module tb_flash_bootloader;
    localparam logic [22:0] FB  = 23'h7FFFFC;
    localparam logic [17:0] RB  = 18'h3FFFE;
    localparam int          WC  = 4;
    localparam int          RW  = 4;
    localparam int          WP  = 3;
    localparam logic [22:0] FB1 = 23'h000010;
    localparam logic [17:0] RB1 = 18'h00100;
`ifdef BOOT_CHECKSUM_EN
    localparam int EXTRA = RW + 1;
    localparam int EXTRA1 = 2;
`else
    localparam int EXTRA = 0;
    localparam int EXTRA1 = 0;
`endif
    localparam int LAT  = WC * (RW + 2) + WP + 2 + EXTRA;
    localparam int LAT1 = 1 * (1 + 2) + 1 + 2 + EXTRA1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start1, ram_ready;
    wire  [15:0] fbus, fbus1;
    logic [22:0] f_addr, f_addr1;
    logic        f_byte, f_vpen, f_rp, f_ce, f_oe, f_we;
    logic        f_byte1, f_vpen1, f_rp1, f_ce1, f_oe1, f_we1;
    logic [17:0] ram_addr, ram_addr1;
    logic [15:0] ram_data, ram_data1, word_idx, word_idx1, checksum, checksum1;
    logic        ram_valid, ram_valid1, busy, busy1, done, done1;
    logic        ram_ready1 = 1'b1;
`ifdef BOOT_CHECKSUM_EN
    logic        boot_err, boot_err1;
`endif

    flash_bootloader #(.FLASH_BASE(FB), .RAM_AW(18), .RAM_BASE(RB), .WORD_COUNT(WC),
                       .READ_WAIT(RW), .WE_PULSE(WP)) dut (
        .clk(clk), .rst(rst), .start(start), .flash_addr(f_addr), .flash_data(fbus),
        .flash_byte(f_byte), .flash_vpen(f_vpen), .flash_rp(f_rp), .flash_ce(f_ce),
        .flash_oe(f_oe), .flash_we(f_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_valid(ram_valid), .ram_ready(ram_ready), .busy(busy), .done(done),
        .word_idx(word_idx), .checksum(checksum)
`ifdef BOOT_CHECKSUM_EN
        , .boot_err(boot_err)
`endif
    );

    flash_bootloader #(.FLASH_BASE(FB1), .RAM_AW(18), .RAM_BASE(RB1), .WORD_COUNT(1),
                       .READ_WAIT(1), .WE_PULSE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .flash_addr(f_addr1), .flash_data(fbus1),
        .flash_byte(f_byte1), .flash_vpen(f_vpen1), .flash_rp(f_rp1), .flash_ce(f_ce1),
        .flash_oe(f_oe1), .flash_we(f_we1), .ram_addr(ram_addr1), .ram_data(ram_data1),
        .ram_valid(ram_valid1), .ram_ready(ram_ready1), .busy(busy1), .done(done1),
        .word_idx(word_idx1), .checksum(checksum1)
`ifdef BOOT_CHECKSUM_EN
        , .boot_err(boot_err1)
`endif
    );

    // Flash models: image words placed at byte addresses base + 2*i (mod 2^23).
    logic [15:0] img [0:WC];
    logic [22:0] img_addr [0:WC];
    logic [15:0] img1 [0:1];
    logic [15:0] flash_word;

    always_comb begin
        flash_word = 16'hDEAD;
        for (int i = 0; i <= WC; i++)
            if (img_addr[i] == f_addr) flash_word = img[i];
    end
    assign fbus  = (!f_ce && !f_oe && f_we) ? flash_word : 16'hzzzz;
    assign fbus1 = (!f_ce1 && !f_oe1 && f_we1) ?
                   ((f_addr1 == FB1) ? img1[0] : (f_addr1 == FB1 + 23'd2) ? img1[1] : 16'hDEAD) : 16'hzzzz;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed { logic [17:0] a; logic [15:0] d; } wr_t;
    wr_t         exp_q[$];
    logic [15:0] exp_sum;
    int          rdy_mode = 0;
    int          stall_left = 0;
    int          stall_cycles = 0;
    int          writes1 = 0;

    // Ready driver: always ready, random, or a 10-cycle stall while word 2 is presented.
    initial begin
        ram_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: ram_ready = 1'($urandom_range(0, 1));
                2: if (ram_valid && word_idx == 16'd2 && stall_left > 0) begin
                       ram_ready = 1'b0;
                       stall_left--;
                   end else ram_ready = 1'b1;
                default: ram_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pops, stall stability, command-phase rules.
    logic        stall_prev = 1'b0;
    logic [17:0] prev_a;
    logic [15:0] prev_d, prev_idx;
    int          cmd_run = 0;
    wr_t         got;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            cmd_run = 0;
        end else begin
            if (stall_prev) begin
                stall_cycles++;
                chk("stall_addr", 32'(ram_addr), 32'(prev_a));
                chk("stall_data", 32'(ram_data), 32'(prev_d));
                chk("stall_idx", 32'(word_idx), 32'(prev_idx));
                chk("stall_ce", 32'(f_ce), 32'd1);
            end
            if (ram_valid && ram_ready) begin
                if (exp_q.size() == 0) chk("unexpected_write", 32'(ram_addr), 32'hFFFFFFFF);
                else begin
                    got = exp_q.pop_front();
                    chk("ram_addr", 32'(ram_addr), 32'(got.a));
                    chk("ram_data", 32'(ram_data), 32'(got.d));
                end
            end
            stall_prev = ram_valid && !ram_ready;
            prev_a = ram_addr; prev_d = ram_data; prev_idx = word_idx;
            if (!f_we) begin
                cmd_run++;
                chk("cmd_bus", 32'(fbus), 32'h00FF);
                chk("cmd_oe", 32'(f_oe), 32'd1);
            end else if (cmd_run != 0) begin
                chk("cmd_len", cmd_run, WP);
                cmd_run = 0;
            end
            if (ram_valid1) begin
                writes1++;
                chk("u1_addr", 32'(ram_addr1), 32'(RB1));
                chk("u1_data", 32'(ram_data1), 32'(img1[0]));
            end
        end
    end

    task automatic load_image(input int bad);
        logic [15:0] s;
        s = 16'h0;
        for (int i = 0; i < WC; i++) begin
            img[i] = 16'($urandom);
            s = s + img[i];
            exp_q.push_back({18'((int'(RB) + i) % (1 << 18)), img[i]});
        end
        img[WC] = s + 16'(bad);
        exp_sum = s;
    endtask

    task automatic run_copy(input int bad, input int exp_lat, input bit use1, input bit poke);
        int n, n1;
        bit poked;
        load_image(bad);
        @(posedge clk); #1;
        start = 1'b1;
        start1 = use1;
        n = 0; n1 = 0; poked = 0;
        do begin
            @(posedge clk); #1;
            n++;
            start1 = 1'b0;
            start = 1'b0;
            if (poke && !poked && word_idx == 16'd1) begin
                start = 1'b1;
                poked = 1;
            end
            if (use1 && done1 && n1 == 0) n1 = n;
        end while (!done && n < 3000);
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        if (exp_lat > 0) chk("done_latency", n, exp_lat);
        if (use1) chk("u1_latency", n1, LAT1);
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("idx_after", 32'(word_idx), WC);
        chk("queue_empty", exp_q.size(), 0);
`ifdef BOOT_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(exp_sum));
        chk("boot_err", 32'(boot_err), (bad != 0) ? 32'd1 : 32'd0);
`else
        chk("checksum", 32'(checksum), 32'd0);
`endif
    endtask

    initial begin
        int n;
        for (int i = 0; i <= WC; i++) img_addr[i] = 23'((int'(FB) + 2 * i) % (1 << 23));
        for (int i = 0; i <= WC; i++) img[i] = 16'h0;
        img1[0] = 16'($urandom);
        img1[1] = img1[0];
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ce", 32'(f_ce), 32'd1);
        chk("rst_oe", 32'(f_oe), 32'd1);
        chk("rst_we", 32'(f_we), 32'd1);
        chk("rst_valid", 32'(ram_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_idx", 32'(word_idx), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        chk("rst_addr", 32'(f_addr), 32'(FB));
        chk("const_pins", {f_byte, f_vpen, f_rp}, 32'd7);
        @(posedge clk); #1;
        rst = 1'b0;

        rdy_mode = 0;
        run_copy(0, LAT, 1'b1, 1'b0);
        chk("u1_writes", writes1, 1);
        chk("u1_done", 32'(done1), 32'd1);

        rdy_mode = 2; stall_left = 10; stall_cycles = 0;
        run_copy(0, LAT + 10, 1'b0, 1'b0);
        chk("stall_cycles", stall_cycles, 10);

        rdy_mode = 1;
        run_copy(0, 0, 1'b0, 1'b1);
        rdy_mode = 1;
        run_copy(0, 0, 1'b0, 1'b0);

        rdy_mode = 0;
        load_image(0);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (!(word_idx == 16'd3 && !f_oe) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk("reach_word3", 32'(n < 3000), 32'd1);
        @(posedge clk); #1;
        chk("in_wait_oe", 32'(f_oe), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ce", 32'(f_ce), 32'd1);
        chk("midrst_oe", 32'(f_oe), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_idx", 32'(word_idx), 32'd0);
        chk("midrst_valid", 32'(ram_valid), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        run_copy(0, LAT, 1'b0, 1'b0);

`ifdef BOOT_CHECKSUM_EN
        rdy_mode = 1;
        run_copy(1, 0, 1'b0, 1'b0);
        chk("err_done", 32'(done), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
